// File: rtl/cpu_bus_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_bus_responder_if : 6502C external bus + host preload port bundle       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface cpu_bus_responder_if #(
  parameter int ADDR_BITS = 8
);
  logic                 phi2;
  logic [15:0]          extAB;
  logic                 RW;
  logic [7:0]           db_in;
  logic [7:0]           db_out;
  logic                 db_oe;
  logic                 RDY;
  logic                 hit;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_BITS-1:0] host_addr;
  logic [7:0]           host_wdata;
  logic                 host_ack;
  logic [7:0]           host_rdata;

  modport slave (
    input  phi2, extAB, RW, db_in, host_req, host_we, host_addr, host_wdata,
    output db_out, db_oe, RDY, hit, host_ack, host_rdata
  );

  modport master (
    output phi2, extAB, RW, db_in, host_req, host_we, host_addr, host_wdata,
    input  db_out, db_oe, RDY, hit, host_ack, host_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_bus_responder : 6502C memory-mapped byte store with RDY wait states    |
// | and a host preload port. Optional trace: define CPU_BUS_RESP_TRACE_EN.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module cpu_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hF000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_bus_responder_if.slave    bus
`ifdef CPU_BUS_RESP_TRACE_EN
  ,
  output logic [15:0]           last_wr_addr,
  output logic [7:0]            last_wr_data,
  output logic [15:0]           wr_count
`endif
);

  localparam int                    c_DEPTH    = 1 << ADDR_BITS;
  localparam int                    c_TAG_W    = 16 - ADDR_BITS;
  localparam logic [c_TAG_W-1:0]    c_BASE_TAG = BASE_ADDR[15:ADDR_BITS];
  localparam logic [4:0]            c_WAIT     = 5'(WAIT_CYCLES);
  localparam bit                    c_NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_phi2_s1;
  logic                 r_phi2_s2;
  logic                 r_phi2_s3;
  logic                 r_rise;
  logic                 r_fall;

  logic [7:0]           r_mem [c_DEPTH];
  logic [ADDR_BITS-1:0] r_idx;
  logic [7:0]           r_db_out;
  logic                 r_db_oe;
  logic                 r_rdy;
  logic                 r_hit;
  logic [3:0]           r_wait_cnt;
  logic                 r_host_ack;
  logic [7:0]           r_host_rdata;
  logic                 r_host_done;

  logic                 w_match;
  logic                 w_edge_pend;
  logic                 w_host_go;
  logic [ADDR_BITS-1:0] w_rd_idx;
  logic [4:0]           w_cnt_inc;
  logic                 w_cap_addr;
  logic                 w_load_rd;
  logic                 w_wait_start;
  logic                 w_wait_inc;
  logic                 w_cpu_we;
  logic                 w_cyc_end;

  // phi2 is asynchronous: two flops to settle, a third to find the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phi2_s1 <= 1'b0;
      r_phi2_s2 <= 1'b0;
      r_phi2_s3 <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_phi2_s1 <= bus.phi2;
      r_phi2_s2 <= r_phi2_s1;
      r_phi2_s3 <= r_phi2_s2;
      r_rise    <= r_phi2_s2 & ~r_phi2_s3;
      r_fall    <= ~r_phi2_s2 & r_phi2_s3;
    end
  end

  assign w_match     = (bus.extAB[15:ADDR_BITS] == c_BASE_TAG);
  assign w_edge_pend = r_rise | r_fall | (r_phi2_s2 ^ r_phi2_s3);
  assign w_cnt_inc   = {1'b0, r_wait_cnt} + 5'd1;
  assign w_rd_idx    = (r_state == S_IDLE) ? bus.extAB[ADDR_BITS-1:0] : r_idx;

  // Host only gets storage while the CPU side is quiet, so the CPU wins collisions
  assign w_host_go   = bus.host_req & ~r_host_done & (r_state == S_IDLE) & ~w_edge_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cap_addr   = 1'b0;
    w_load_rd    = 1'b0;
    w_wait_start = 1'b0;
    w_wait_inc   = 1'b0;
    w_cpu_we     = 1'b0;
    w_cyc_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rise && w_match) begin
          w_cap_addr = 1'b1;
          if (!bus.RW) begin
            w_state_nxt = S_WRITE;
          end else if (c_NO_WAIT) begin
            w_state_nxt = S_READ;
            w_load_rd   = 1'b1;
          end else begin
            w_state_nxt  = S_WAIT;
            w_wait_start = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_fall) begin
          w_wait_inc = 1'b1;
          if (w_cnt_inc == c_WAIT) begin
            w_state_nxt = S_READ;
            w_load_rd   = 1'b1;
          end
        end
      end
      S_READ: begin
        if (r_fall) begin
          w_state_nxt = S_IDLE;
          w_cyc_end   = 1'b1;
        end
      end
      S_WRITE: begin
        if (r_fall) begin
          w_state_nxt = S_IDLE;
          w_cpu_we    = 1'b1;
          w_cyc_end   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_db_out     <= 8'h00;
      r_db_oe      <= 1'b0;
      r_rdy        <= 1'b1;
      r_hit        <= 1'b0;
      r_wait_cnt   <= 4'd0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= 8'h00;
      r_host_done  <= 1'b0;
    end else begin
      r_host_ack <= w_host_go;
      if (w_host_go && !bus.host_we) begin
        r_host_rdata <= r_mem[bus.host_addr];
      end
      if (w_host_go) begin
        r_host_done <= 1'b1;
      end else if (!bus.host_req) begin
        r_host_done <= 1'b0;
      end

      if (w_cap_addr) begin
        r_idx <= bus.extAB[ADDR_BITS-1:0];
        r_hit <= 1'b1;
      end
      if (w_wait_start) begin
        r_rdy      <= 1'b0;
        r_wait_cnt <= 4'd0;
      end
      if (w_wait_inc) begin
        r_wait_cnt <= w_cnt_inc[3:0];
      end
      if (w_load_rd) begin
        r_db_out <= r_mem[w_rd_idx];
        r_db_oe  <= 1'b1;
        r_rdy    <= 1'b1;
      end
      if (w_cyc_end) begin
        r_db_oe <= 1'b0;
        r_hit   <= 1'b0;
      end
    end
  end

  // Storage is deliberately unreset; the CPU write is ordered last so it wins
  always_ff @(posedge clk) begin
    if (w_host_go && bus.host_we) begin
      r_mem[bus.host_addr] <= bus.host_wdata;
    end
    if (w_cpu_we) begin
      r_mem[r_idx] <= bus.db_in;
    end
  end

`ifdef CPU_BUS_RESP_TRACE_EN
  logic [15:0] r_trace_addr;
  logic [15:0] r_last_wr_addr;
  logic [7:0]  r_last_wr_data;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trace_addr   <= 16'h0000;
      r_last_wr_addr <= 16'h0000;
      r_last_wr_data <= 8'h00;
      r_wr_count     <= 16'h0000;
    end else begin
      if (w_cap_addr) begin
        r_trace_addr <= bus.extAB;
      end
      if (w_cpu_we) begin
        r_last_wr_addr <= r_trace_addr;
        r_last_wr_data <= bus.db_in;
        r_wr_count     <= r_wr_count + 16'd1;
      end
    end
  end

  assign last_wr_addr = r_last_wr_addr;
  assign last_wr_data = r_last_wr_data;
  assign wr_count     = r_wr_count;
`endif

  assign bus.db_out     = r_db_out;
  assign bus.db_oe      = r_db_oe;
  assign bus.RDY        = r_rdy;
  assign bus.hit        = r_hit;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_bus_responder : scoreboard bench, one zero-wait and one 2-wait DUT  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_cpu_bus_responder;
  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        phi2_0, phi2_2, RW;
  logic [15:0] extAB;
  logic [7:0]  db_in;
  logic        host_req0, host_req2, host_we;
  logic [7:0]  host_addr, host_wdata;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mdl0 [256];
  logic [7:0]  mdl2 [256];
  int          wr_cnt0;

  logic        cyc_any_oe, cyc_any_hit, cyc_any_rdy_low, cyc_oe_while_low;
  logic        cyc_oe_at_fall, cyc_timeout;
  logic [7:0]  cyc_data;
  int          cyc_rdy_low_falls;
  time         cyc_fall_t;
  logic        h_got_ack, h_pulse_ok;
  logic [7:0]  h_rdata;
  time         h_ack_t;

  cpu_bus_responder_if #(.ADDR_BITS(8)) bus0();
  cpu_bus_responder_if #(.ADDR_BITS(8)) bus2();

  assign bus0.phi2 = phi2_0;       assign bus2.phi2 = phi2_2;
  assign bus0.extAB = extAB;       assign bus2.extAB = extAB;
  assign bus0.RW = RW;             assign bus2.RW = RW;
  assign bus0.db_in = db_in;       assign bus2.db_in = db_in;
  assign bus0.host_req = host_req0; assign bus2.host_req = host_req2;
  assign bus0.host_we = host_we;   assign bus2.host_we = host_we;
  assign bus0.host_addr = host_addr; assign bus2.host_addr = host_addr;
  assign bus0.host_wdata = host_wdata; assign bus2.host_wdata = host_wdata;

`ifdef CPU_BUS_RESP_TRACE_EN
  logic [15:0] tr_addr0, tr_cnt0, tr_addr2, tr_cnt2;
  logic [7:0]  tr_data0, tr_data2;
`endif

  cpu_bus_responder #(.BASE_ADDR(16'hF000), .ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef CPU_BUS_RESP_TRACE_EN
    , .last_wr_addr(tr_addr0), .last_wr_data(tr_data0), .wr_count(tr_cnt0)
`endif
  );

  cpu_bus_responder #(.BASE_ADDR(16'hF000), .ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef CPU_BUS_RESP_TRACE_EN
    , .last_wr_addr(tr_addr2), .last_wr_data(tr_data2), .wr_count(tr_cnt2)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic observe(input int s);
    logic oe, rdy, ht;
    oe  = (s == 2) ? bus2.db_oe : bus0.db_oe;
    rdy = (s == 2) ? bus2.RDY   : bus0.RDY;
    ht  = (s == 2) ? bus2.hit   : bus0.hit;
    if (oe === 1'b1) cyc_any_oe = 1'b1;
    if (ht === 1'b1) cyc_any_hit = 1'b1;
    if (rdy !== 1'b1) cyc_any_rdy_low = 1'b1;
    if (oe === 1'b1 && rdy !== 1'b1) cyc_oe_while_low = 1'b1;
  endtask

  // One CPU bus cycle, repeated while RDY is low at the phi2 fall
  task automatic cpu_cycle(input int s, input logic [15:0] a, input logic rw, input logic [7:0] wd);
    logic stretch;
    int   periods;
    cyc_any_oe = 0; cyc_any_hit = 0; cyc_any_rdy_low = 0; cyc_oe_while_low = 0;
    cyc_oe_at_fall = 0; cyc_data = 8'h00; cyc_rdy_low_falls = 0;
    @(negedge clk);
    extAB = a; RW = rw; db_in = wd;
    stretch = 1'b1;
    periods = 0;
    while (stretch && periods < 8) begin
      if (s == 2) phi2_2 = 1'b1; else phi2_0 = 1'b1;
      repeat (PH) begin @(negedge clk); observe(s); end
      stretch = (((s == 2) ? bus2.RDY : bus0.RDY) === 1'b0);
      if (stretch) cyc_rdy_low_falls++;
      cyc_oe_at_fall = (s == 2) ? bus2.db_oe : bus0.db_oe;
      cyc_data       = (s == 2) ? bus2.db_out : bus0.db_out;
      cyc_fall_t     = $time;
      if (s == 2) phi2_2 = 1'b0; else phi2_0 = 1'b0;
      repeat (PH) begin @(negedge clk); observe(s); end
      periods++;
    end
    cyc_timeout = stretch;
  endtask

  task automatic host_access(input int s, input logic we, input logic [7:0] a,
                             input logic [7:0] wd, input int dly);
    int n;
    h_got_ack = 0; h_pulse_ok = 0; h_rdata = 8'h00;
    repeat (dly) @(negedge clk);
    host_we = we; host_addr = a; host_wdata = wd;
    if (s == 2) host_req2 = 1'b1; else host_req0 = 1'b1;
    n = 0;
    while (n < 80 && !h_got_ack) begin
      @(negedge clk);
      n++;
      if (((s == 2) ? bus2.host_ack : bus0.host_ack) === 1'b1) begin
        h_got_ack = 1'b1;
        h_rdata   = (s == 2) ? bus2.host_rdata : bus0.host_rdata;
        h_ack_t   = $time;
      end
    end
    host_req0 = 1'b0; host_req2 = 1'b0;
    @(negedge clk);
    h_pulse_ok = (((s == 2) ? bus2.host_ack : bus0.host_ack) === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus0.db_out !== 8'h00) begin errors++; $display("FAIL reset_db_out got %h exp 00", bus0.db_out); end
    checks++; if (bus0.db_oe !== 1'b0) begin errors++; $display("FAIL reset_db_oe got %b exp 0", bus0.db_oe); end
    checks++; if (bus0.RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", bus0.RDY); end
    checks++; if (bus2.RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy2 got %b exp 1", bus2.RDY); end
    checks++; if (bus0.hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bus0.hit); end
    checks++; if (bus0.host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack got %b exp 0", bus0.host_ack); end
    checks++; if (bus0.host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata got %h exp 00", bus0.host_rdata); end
`ifdef CPU_BUS_RESP_TRACE_EN
    checks++; if (tr_cnt0 !== 16'h0000 || tr_addr0 !== 16'h0000 || tr_data0 !== 8'h00) begin
      errors++; $display("FAIL reset_trace got %h/%h/%h exp 0/0/0", tr_addr0, tr_data0, tr_cnt0); end
`endif
    rst = 1'b0;
    wr_cnt0 = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_host();
    logic [7:0] idx [5] = '{8'h00, 8'h10, 8'h20, 8'hFF, 8'h01};
    logic [7:0] dat [5] = '{8'h5A, 8'hA9, 8'h42, 8'hE7, 8'h3E};
    for (int i = 0; i < 5; i++) begin
      host_access((i == 4) ? 2 : 0, 1'b1, idx[i], dat[i], 0);
      if (i == 4) mdl2[idx[i]] = dat[i]; else mdl0[idx[i]] = dat[i];
      checks++; if (!h_got_ack) begin errors++; $display("FAIL host_wr_ack idx %h got 0 exp 1", idx[i]); end
    end
    exp_q.push_back(mdl0[8'h10]);
    host_access(0, 1'b0, 8'h10, 8'h00, 0);
    checks++; if (!h_got_ack) begin errors++; $display("FAIL host_rd_ack got 0 exp 1"); end
    checks++; if (!h_pulse_ok) begin errors++; $display("FAIL host_ack_pulse got wide exp 1clk"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL host_rd_data got none exp entry"); end
    else begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (h_rdata !== e) begin errors++; $display("FAIL host_rd_data got %h exp %h", h_rdata, e); end
    end
  endtask

  task automatic test_cpu_read();
    logic [15:0] addrs [3] = '{16'hF010, 16'hF000, 16'hF020};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mdl0[addrs[i][7:0]]);
      cpu_cycle(0, addrs[i], 1'b1, 8'h00);
      checks++; if (cyc_oe_at_fall !== 1'b1) begin errors++; $display("FAIL rd_oe_%h got %b exp 1", addrs[i], cyc_oe_at_fall); end
      checks++; if (cyc_any_rdy_low) begin errors++; $display("FAIL rd_rdy_%h got low exp 1", addrs[i]); end
      checks++; if (!cyc_any_hit) begin errors++; $display("FAIL rd_hit_%h got 0 exp 1", addrs[i]); end
      checks++;
      begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (cyc_data !== e) begin errors++; $display("FAIL rd_data_%h got %h exp %h", addrs[i], cyc_data, e); end
      end
    end
  endtask

  task automatic test_cpu_write();
    cpu_cycle(0, 16'hF0FF, 1'b0, 8'h5C);
    mdl0[8'hFF] = 8'h5C;
    wr_cnt0++;
    checks++; if (cyc_any_oe) begin errors++; $display("FAIL wr_oe got 1 exp 0"); end
    checks++; if (!cyc_any_hit) begin errors++; $display("FAIL wr_hit got 0 exp 1"); end
`ifdef CPU_BUS_RESP_TRACE_EN
    checks++; if (tr_addr0 !== 16'hF0FF) begin errors++; $display("FAIL trace_addr got %h exp F0FF", tr_addr0); end
    checks++; if (tr_data0 !== 8'h5C) begin errors++; $display("FAIL trace_data got %h exp 5C", tr_data0); end
    checks++; if (tr_cnt0 !== 16'(wr_cnt0)) begin errors++; $display("FAIL trace_cnt got %h exp %h", tr_cnt0, 16'(wr_cnt0)); end
`endif
    exp_q.push_back(mdl0[8'hFF]);
    cpu_cycle(0, 16'hF0FF, 1'b1, 8'h00);
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (cyc_oe_at_fall !== 1'b1 || cyc_data !== e) begin
        errors++; $display("FAIL wr_readback got oe=%b %h exp oe=1 %h", cyc_oe_at_fall, cyc_data, e); end
    end
  endtask

  task automatic test_miss();
    logic [15:0] addrs [2] = '{16'h0200, 16'hEFFF};
    for (int i = 0; i < 2; i++) begin
      cpu_cycle(0, addrs[i], 1'b1, 8'h00);
      checks++; if (cyc_any_oe || cyc_any_rdy_low || cyc_any_hit) begin
        errors++; $display("FAIL miss_%h got oe=%b rdylow=%b hit=%b exp 0/0/0", addrs[i], cyc_any_oe, cyc_any_rdy_low, cyc_any_hit); end
    end
    cpu_cycle(0, 16'h0200, 1'b0, 8'hEE);
    checks++; if (cyc_any_oe || cyc_any_hit) begin errors++; $display("FAIL miss_wr got oe=%b hit=%b exp 0/0", cyc_any_oe, cyc_any_hit); end
    exp_q.push_back(mdl0[8'h00]);
    host_access(0, 1'b0, 8'h00, 8'h00, 0);
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (!h_got_ack || h_rdata !== e) begin errors++; $display("FAIL miss_store got %h ack=%b exp %h", h_rdata, h_got_ack, e); end
    end
  endtask

  task automatic test_wait();
    exp_q.push_back(mdl2[8'h01]);
    cpu_cycle(2, 16'hF001, 1'b1, 8'h00);
    checks++; if (cyc_timeout) begin errors++; $display("FAIL wait_timeout got stuck exp release"); end
    checks++; if (cyc_rdy_low_falls != 2) begin errors++; $display("FAIL wait_periods got %0d exp 2", cyc_rdy_low_falls); end
    checks++; if (cyc_oe_while_low) begin errors++; $display("FAIL wait_oe_early got 1 exp 0"); end
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (cyc_oe_at_fall !== 1'b1 || cyc_data !== e) begin
        errors++; $display("FAIL wait_data got oe=%b %h exp oe=1 %h", cyc_oe_at_fall, cyc_data, e); end
    end
  endtask

  task automatic test_reset_mid_cycle();
    int n;
    @(negedge clk);
    extAB = 16'hF001; RW = 1'b1; phi2_2 = 1'b1;
    n = 0;
    while (n < 20 && bus2.RDY !== 1'b0) begin @(negedge clk); n++; end
    checks++; if (bus2.RDY !== 1'b0) begin errors++; $display("FAIL rstwait_enter got RDY=%b exp 0", bus2.RDY); end
    rst = 1'b1;
    #1;
    checks++; if (bus2.RDY !== 1'b1 || bus2.db_oe !== 1'b0 || bus2.hit !== 1'b0) begin
      errors++; $display("FAIL rstwait_async got rdy=%b oe=%b hit=%b exp 1/0/0", bus2.RDY, bus2.db_oe, bus2.hit); end
    @(negedge clk);
    rst = 1'b0; phi2_2 = 1'b0; wr_cnt0 = 0;
    repeat (10) @(negedge clk);
    exp_q.push_back(mdl2[8'h01]);
    cpu_cycle(2, 16'hF001, 1'b1, 8'h00);
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (cyc_rdy_low_falls != 2 || cyc_data !== e) begin
        errors++; $display("FAIL rstwait_after got waits=%0d %h exp 2 %h", cyc_rdy_low_falls, cyc_data, e); end
    end

    @(negedge clk);
    extAB = 16'hF020; RW = 1'b0; db_in = 8'h77; phi2_0 = 1'b1;
    n = 0;
    while (n < 20 && bus0.hit !== 1'b1) begin @(negedge clk); n++; end
    checks++; if (bus0.hit !== 1'b1) begin errors++; $display("FAIL rstwr_enter got hit=%b exp 1", bus0.hit); end
    rst = 1'b1;
    #1;
    checks++; if (bus0.hit !== 1'b0 || bus0.db_oe !== 1'b0) begin
      errors++; $display("FAIL rstwr_async got hit=%b oe=%b exp 0/0", bus0.hit, bus0.db_oe); end
    @(negedge clk);
    rst = 1'b0; phi2_0 = 1'b0; wr_cnt0 = 0;
    repeat (10) @(negedge clk);
    exp_q.push_back(mdl0[8'h20]);
    host_access(0, 1'b0, 8'h20, 8'h00, 0);
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (h_rdata !== e) begin errors++; $display("FAIL rstwr_discard got %h exp %h", h_rdata, e); end
    end
`ifdef CPU_BUS_RESP_TRACE_EN
    checks++; if (tr_cnt0 !== 16'(wr_cnt0)) begin errors++; $display("FAIL rstwr_trace_cnt got %h exp %h", tr_cnt0, 16'(wr_cnt0)); end
`endif
  endtask

  task automatic test_collision();
    exp_q.push_back(mdl0[8'h10]);
    fork
      cpu_cycle(0, 16'hF010, 1'b1, 8'h00);
      host_access(0, 1'b1, 8'h10, 8'h11, 3);
    join
    mdl0[8'h10] = 8'h11;
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (cyc_data !== e) begin errors++; $display("FAIL coll_cpu_data got %h exp %h", cyc_data, e); end
    end
    checks++; if (!h_got_ack) begin errors++; $display("FAIL coll_host_ack got 0 exp 1"); end
    checks++; if (h_ack_t <= cyc_fall_t) begin errors++; $display("FAIL coll_order got ack@%0t exp after %0t", h_ack_t, cyc_fall_t); end
    exp_q.push_back(mdl0[8'h10]);
    host_access(0, 1'b0, 8'h10, 8'h00, 0);
    checks++;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (h_rdata !== e) begin errors++; $display("FAIL coll_host_data got %h exp %h", h_rdata, e); end
    end
  endtask

  initial begin
    phi2_0 = 0; phi2_2 = 0; RW = 1; extAB = 16'h0000; db_in = 8'h00;
    host_req0 = 0; host_req2 = 0; host_we = 0; host_addr = 8'h00; host_wdata = 8'h00;
    wr_cnt0 = 0;
    test_reset();
    test_host();
    test_cpu_read();
    test_cpu_write();
    test_miss();
    test_wait();
    test_reset_mid_cycle();
    test_collision();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
